// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci-chain unwinder: state encoding and
// default operand width / step count.
package fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fib_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEPS = 4;

endpackage

// File: rtl/fib_unwind_step.sv
// One backward step of the add chain: from (x(n+1), x(n)) produce
// (x(n), x(n-1)) where x(n-1) = x(n+1) - x(n), modulo 2^WIDTH.
module unwind_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  assign next_hi = lo;
  assign next_lo = hi - lo;

endmodule

// File: rtl/fib_unwind.sv
// Iterative inverse of the forward add chain: given the last two terms it
// walks back STEPS times through one shared subtractor to recover the seeds.
module fib_unwind
  import fib_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEPS = DEF_STEPS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] seed_a,
  output logic [WIDTH-1:0] seed_b
);

  // Handshake: start is taken on a rising edge only while ready=1 (IDLE or
  // DONE); hi/lo are captured on that edge only. done is a one-cycle pulse and
  // seed_a/seed_b stay valid from it until the next DONE entry or reset.

  localparam int CW = (STEPS > 0) ? $clog2(STEPS + 1) : 1;

  fib_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             accept;
  logic             last_step;

  unwind_step #(.WIDTH(WIDTH)) u_step (
    .hi      (hi_r),
    .lo      (lo_r),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  assign accept    = start && (state_q != ST_RUN);
  assign last_step = (state_q == ST_RUN) && (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = (STEPS == 0) ? ST_DONE : ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r   <= '0;
      lo_r   <= '0;
      cnt_q  <= '0;
      seed_a <= '0;
      seed_b <= '0;
    end else if (accept) begin
      hi_r  <= hi;
      lo_r  <= lo;
      cnt_q <= CW'(STEPS);
      // With zero steps the operands already are the seeds.
      if (STEPS == 0) begin
        seed_b <= hi;
        seed_a <= lo;
      end
    end else if (state_q == ST_RUN) begin
      hi_r  <= step_hi;
      lo_r  <= step_lo;
      cnt_q <= cnt_q - CW'(1);
      if (last_step) begin
        seed_b <= step_hi;
        seed_a <= step_lo;
      end
    end
  end

  assign ready = (state_q != ST_RUN);
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_fib_unwind.sv
// Bench for fib_unwind: vector table, randomized round trips against a
// forward add-chain model, handshake/reset sequences and STEPS=0/1 corners.
module tb_fib_unwind;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0, start0 = 1'b0, start1 = 1'b0;
  logic [W-1:0] hi = '0, lo = '0, hi0 = '0, lo0 = '0, hi1 = '0, lo1 = '0;
  logic         ready, busy, done, ready0, busy0, done0, ready1, busy1, done1;
  logic [W-1:0] seed_a, seed_b, seed_a0, seed_b0, seed_a1, seed_b1;

  logic [2*W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  fib_unwind #(.WIDTH(W), .STEPS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .hi(hi), .lo(lo),
    .ready(ready), .busy(busy), .done(done), .seed_a(seed_a), .seed_b(seed_b)
  );

  fib_unwind #(.WIDTH(W), .STEPS(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .hi(hi0), .lo(lo0),
    .ready(ready0), .busy(busy0), .done(done0), .seed_a(seed_a0), .seed_b(seed_b0)
  );

  fib_unwind #(.WIDTH(W), .STEPS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .hi(hi1), .lo(lo1),
    .ready(ready1), .busy(busy1), .done(done1), .seed_a(seed_a1), .seed_b(seed_b1)
  );

  always #5 clk = ~clk;

  // Forward add chain from seeds (a, b) run n times; returns {x(n+1), x(n)}.
  function automatic logic [2*W-1:0] chain_tail(logic [W-1:0] a, logic [W-1:0] b, int n);
    logic [W-1:0] x[$];
    x.push_back(a);
    x.push_back(b);
    for (int i = 2; i <= n + 1; i++) x.push_back(x[i-1] + x[i-2]);
    return {x[n+1], x[n]};
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called on the first negedge after the accept edge; stops on the done negedge.
  task automatic wait_done(output int k, output int nb);
    k = 0;
    nb = 0;
    while (done !== 1'b1 && k < 20) begin
      if (busy) nb++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_result(input string name);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check(name, {seed_a, seed_b}, e);
    end
  endtask

  task automatic do_op(input logic [W-1:0] h, input logic [W-1:0] l,
                       input logic [W-1:0] ea, input logic [W-1:0] eb, input string name);
    int k, nb;
    @(negedge clk);
    start = 1'b1; hi = h; lo = l;
    exp_q.push_back({ea, eb});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; hi = $urandom; lo = $urandom;
    wait_done(k, nb);
    check({name, "_latency"}, 64'(k), 64'd4);
    check({name, "_busy_cycles"}, 64'(nb), 64'd4);
    check({name, "_ready_at_done"}, 64'(ready), 64'd1);
    check_result({name, "_seeds"});
    @(negedge clk);
    check({name, "_done_pulse"}, {62'd0, done, ready}, 64'd1);
  endtask

  initial begin
    vec_t vecs[5];
    logic [2*W-1:0] t;
    logic [W-1:0] a, b;
    int k, nb, ndone;

    t = chain_tail(32'h12345678, 32'h9ABCDEF0, 4);
    vecs[0] = '{hi: 32'd13, lo: 32'd8,  ea: 32'd1,          eb: 32'd2};
    vecs[1] = '{hi: 32'd7,  lo: 32'd4,  ea: 32'hFFFFFFFF,   eb: 32'd2};
    vecs[2] = '{hi: t[2*W-1:W], lo: t[W-1:0], ea: 32'h12345678, eb: 32'h9ABCDEF0};
    vecs[3] = '{hi: 32'd21, lo: 32'd13, ea: 32'd2,          eb: 32'd3};
    vecs[4] = '{hi: 32'd0,  lo: 32'd0,  ea: 32'd0,          eb: 32'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_flags", {61'd0, ready, busy, done}, 64'b100);
    check("reset_seeds", {seed_a, seed_b}, 64'd0);
    check("reset_flags_s0", {61'd0, ready0, busy0, done0}, 64'b100);
    check("reset_flags_s1", {61'd0, ready1, busy1, done1}, 64'b100);

    for (int i = 0; i < 5; i++)
      do_op(vecs[i].hi, vecs[i].lo, vecs[i].ea, vecs[i].eb, $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = (i < 3) ? W'($urandom_range(0, 3)) : $urandom;
      t = chain_tail(a, b, 4);
      do_op(t[2*W-1:W], t[W-1:0], a, b, $sformatf("rand%0d", i));
    end

    // Start during RUN is dropped; start in the DONE cycle is taken back-to-back.
    @(negedge clk);
    start = 1'b1; hi = 32'd13; lo = 32'd8;
    exp_q.push_back({32'd1, 32'd2});
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; hi = 32'd100; lo = 32'd50;
    @(negedge clk);
    start = 1'b0;
    wait_done(k, nb);
    check("hs_first_latency", 64'(k), 64'd3);
    check_result("hs_first_seeds");
    start = 1'b1; hi = 32'd21; lo = 32'd13;
    exp_q.push_back({32'd2, 32'd3});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("hs_b2b_busy", 64'(busy), 64'd1);
    wait_done(k, nb);
    check("hs_b2b_latency", 64'(k), 64'd4);
    check_result("hs_b2b_seeds");

    // Reset two cycles after an accept aborts the operation.
    @(negedge clk);
    start = 1'b1; hi = 32'd13; lo = 32'd8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_flags", {61'd0, ready, busy, done}, 64'b100);
    check("rst_mid_seeds", {seed_a, seed_b}, 64'd0);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_mid_no_done", 64'(ndone), 64'd0);

    // STEPS=0: done on the cycle after accept, operands pass straight through.
    @(negedge clk);
    start0 = 1'b1; hi0 = 32'd9; lo0 = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    check("s0_flags", {61'd0, ready0, busy0, done0}, 64'b101);
    check("s0_seeds", {seed_a0, seed_b0}, {32'd5, 32'd9});
    @(negedge clk);
    check("s0_after", {61'd0, ready0, busy0, done0}, 64'b100);

    // STEPS=1: one RUN cycle then DONE.
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin a = 32'd4; b = 32'd5; end
      else begin a = $urandom; b = $urandom; end
      t = chain_tail(a, b, 1);
      @(negedge clk);
      start1 = 1'b1; hi1 = t[2*W-1:W]; lo1 = t[W-1:0];
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0; hi1 = $urandom; lo1 = $urandom;
      check($sformatf("s1_run%0d", i), {61'd0, ready1, busy1, done1}, 64'b010);
      @(negedge clk);
      check($sformatf("s1_done%0d", i), {61'd0, ready1, busy1, done1}, 64'b101);
      check($sformatf("s1_seeds%0d", i), {seed_a1, seed_b1}, {a, b});
    end

    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      @(negedge clk);
      start0 = 1'b1; hi0 = b; lo0 = a;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      check($sformatf("s0_rand%0d", i), {seed_a0, seed_b0}, {a, b});
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
